// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mem_arb miss-refill controller.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {SEL_I, SEL_D} sel_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [2:0]  trd;
  } slot_t;

  localparam int          MEM_TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] DEAD_BEEF           = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_arb_if.sv
// External memory port shared by instruction and data misses.
interface mem_arb_if;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_wr, mem_addr, mem_wdata,
                  input  mem_gnt, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_wr, mem_addr, mem_wdata,
                  output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/mem_arb_slot.sv
// One-entry pending-miss holder: load when empty, clear on response or kill.
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  logic       issued,
  input  logic       kill,
  input  logic [2:0] kill_trd,
  input  slot_t      din,
  output logic       busy,
  output logic       kill_hit,
  output logic       ovf,
  output slot_t      q
);
  // A slot already handed to memory must finish its access, so kill only hits idle entries.
  assign kill_hit = busy && kill && !issued && (q.trd == kill_trd);
  assign ovf      = load && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      q    <= '0;
    end else if (clear || kill_hit) begin
      busy <= 1'b0;
    end else if (load && !busy) begin
      busy <= 1'b1;
      q    <= din;
    end
  end
endmodule

// File: rtl/mem_arb.sv
// Round-robin I/D miss arbiter driving one memory port and per-thread resume.
// Optional build macro: MEM_TIMEOUT_EN (bounded WAIT with DEAD_BEEF fill).
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_trd,
  input  logic        d_req,
  input  logic        d_req_wr,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [2:0]  d_req_trd,
  input  logic        kill,
  input  logic [2:0]  kill_trd,
  mem_arb_if.master   mem,
  output logic        i_busy,
  output logic        d_busy,
  output logic        i_done,
  output logic        d_done,
  output logic [31:0] fill_data,
  output logic [7:0]  trd_resume,
  output logic        err
);
  state_t state, nxt;
  sel_t   sel, sel_nxt, last, last_nxt;
  slot_t  i_q, d_q, cur;
  logic   i_kill, d_kill, i_ovf, d_ovf, i_avail, d_avail;
  logic   killed, tmo, resp_ok;

  mem_arb_slot u_i_slot (
    .clk, .rst_n, .load(i_req), .clear(state == RESP && sel == SEL_I),
    .issued(state != IDLE && sel == SEL_I), .kill, .kill_trd,
    .din('{addr: i_req_addr, wdata: 32'd0, wr: 1'b0, trd: i_req_trd}),
    .busy(i_busy), .kill_hit(i_kill), .ovf(i_ovf), .q(i_q)
  );

  mem_arb_slot u_d_slot (
    .clk, .rst_n, .load(d_req), .clear(state == RESP && sel == SEL_D),
    .issued(state != IDLE && sel == SEL_D), .kill, .kill_trd,
    .din('{addr: d_req_addr, wdata: d_req_wdata, wr: d_req_wr, trd: d_req_trd}),
    .busy(d_busy), .kill_hit(d_kill), .ovf(d_ovf), .q(d_q)
  );

  assign cur     = (sel == SEL_I) ? i_q : d_q;
  assign i_avail = i_busy && !i_kill;
  assign d_avail = d_busy && !d_kill;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state == WAIT)  tmo_cnt <= tmo_cnt + 8'd1;
    else                     tmo_cnt <= '0;
  end

  assign tmo = (state == WAIT) && !mem.mem_rvalid && (tmo_cnt == TMO_LAST);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= SEL_I;
      last  <= SEL_D;
    end else begin
      state <= nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    nxt      = state;
    sel_nxt  = sel;
    last_nxt = last;
    case (state)
      IDLE: if (i_avail || d_avail) begin
        nxt = ISSUE;
        if (i_avail && d_avail) sel_nxt = (last == SEL_I) ? SEL_D : SEL_I;
        else                    sel_nxt = i_avail ? SEL_I : SEL_D;
        last_nxt = sel_nxt;
      end
      ISSUE: if (mem.mem_gnt) nxt = cur.wr ? RESP : WAIT;
      WAIT:  if (mem.mem_rvalid || tmo) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Killed in flight: the access completes but its completion is silenced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 killed <= 1'b0;
    else if (state == IDLE)     killed <= 1'b0;
    else if ((state == ISSUE || state == WAIT) && kill && kill_trd == cur.trd)
                                killed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_data <= '0;
      err       <= 1'b0;
    end else begin
      if (state == WAIT && mem.mem_rvalid) fill_data <= mem.mem_rdata;
      else if (tmo)                        fill_data <= DEAD_BEEF;
      if (i_ovf || d_ovf || tmo)           err       <= 1'b1;
    end
  end

  assign mem.mem_req   = (state == ISSUE);
  assign mem.mem_wr    = (state == ISSUE) && cur.wr;
  assign mem.mem_addr  = (state == ISSUE) ? cur.addr  : 32'd0;
  assign mem.mem_wdata = (state == ISSUE) ? cur.wdata : 32'd0;

  assign resp_ok    = (state == RESP) && !killed;
  assign i_done     = resp_ok && sel == SEL_I;
  assign d_done     = resp_ok && sel == SEL_D;
  assign trd_resume = resp_ok ? (8'd1 << cur.trd) : 8'd0;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: reads, ties, store, overflow, kills, reset, timeout.
module tb_mem_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_req_wr = 1'b0, kill = 1'b0;
  logic [31:0] i_req_addr = '0, d_req_addr = '0, d_req_wdata = '0;
  logic [2:0]  i_req_trd = '0, d_req_trd = '0, kill_trd = '0;
  logic        i_busy, d_busy, i_done, d_done, err;
  logic [31:0] fill_data;
  logic [7:0]  trd_resume;
  int          n_cmp = 0, n_bad = 0, acc_cnt = 0, acc0;

  mem_arb_if mem ();

  mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_req_addr(i_req_addr), .i_req_trd(i_req_trd),
    .d_req(d_req), .d_req_wr(d_req_wr), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_trd(d_req_trd),
    .kill(kill), .kill_trd(kill_trd), .mem(mem),
    .i_busy(i_busy), .d_busy(d_busy), .i_done(i_done), .d_done(d_done),
    .fill_data(fill_data), .trd_resume(trd_resume), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem.mem_req && mem.mem_gnt) acc_cnt = acc_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Entered in the ISSUE cycle; returns in the IDLE cycle after RESP.
  task automatic read_xact(input string tag, input logic [31:0] a, input logic [31:0] rd,
                           input bit is_i, input logic [7:0] res);
    chk({tag, "_req"}, {31'd0, mem.mem_req}, 32'd1);
    chk({tag, "_addr"}, mem.mem_addr, a);
    chk({tag, "_wr"}, {31'd0, mem.mem_wr}, 32'd0);
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    mem.mem_rvalid = 1'b1;
    mem.mem_rdata = rd;
    tick();
    mem.mem_rvalid = 1'b0;
    chk({tag, "_idone"}, {31'd0, i_done}, {31'd0, is_i});
    chk({tag, "_ddone"}, {31'd0, d_done}, {31'd0, !is_i});
    chk({tag, "_fill"}, fill_data, rd);
    chk({tag, "_resume"}, {24'd0, trd_resume}, {24'd0, res});
    tick();
  endtask

  initial begin
    mem.mem_gnt = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata = '0;
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem.mem_req}, 32'd0);
    chk("rst_busy", {30'd0, i_busy, d_busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_resume", {24'd0, trd_resume}, 32'd0);
    chk("rst_fill", fill_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // single instruction read, zero-wait memory
    i_req = 1'b1; i_req_addr = 32'h100; i_req_trd = 3'd3;
    tick();
    i_req = 1'b0;
    chk("r1_busy", {31'd0, i_busy}, 32'd1);
    chk("r1_noreq", {31'd0, mem.mem_req}, 32'd0);
    tick();
    read_xact("r1", 32'h100, 32'hCAFE_0001, 1'b1, 8'h08);
    chk("r1_clr", {31'd0, i_busy}, 32'd0);

    // tie after an I service: D goes first
    i_req = 1'b1; i_req_addr = 32'h300; i_req_trd = 3'd1;
    d_req = 1'b1; d_req_wr = 1'b0; d_req_addr = 32'h400; d_req_trd = 3'd4;
    tick();
    i_req = 1'b0; d_req = 1'b0;
    chk("tA_busy", {30'd0, i_busy, d_busy}, 32'd3);
    tick();
    read_xact("tA_d", 32'h400, 32'h22, 1'b0, 8'h10);
    tick();
    read_xact("tA_i", 32'h300, 32'h11, 1'b1, 8'h02);
    chk("tA_clr", {30'd0, i_busy, d_busy}, 32'd0);

    // store with grant held off three cycles
    d_req = 1'b1; d_req_wr = 1'b1; d_req_addr = 32'h200; d_req_wdata = 32'h55; d_req_trd = 3'd5;
    tick();
    d_req = 1'b0; d_req_wr = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_req", {31'd0, mem.mem_req}, 32'd1);
      chk("st_addr", mem.mem_addr, 32'h200);
      chk("st_wdata", mem.mem_wdata, 32'h55);
      chk("st_wr", {31'd0, mem.mem_wr}, 32'd1);
      if (k == 3) mem.mem_gnt = 1'b1;
      tick();
    end
    mem.mem_gnt = 1'b0;
    chk("st_ddone", {31'd0, d_done}, 32'd1);
    chk("st_idone", {31'd0, i_done}, 32'd0);
    chk("st_resume", {24'd0, trd_resume}, 32'h20);
    tick();
    chk("st_clr", {31'd0, d_busy}, 32'd0);

    // tie after a D service: I goes first
    i_req = 1'b1; i_req_addr = 32'h500; i_req_trd = 3'd0;
    d_req = 1'b1; d_req_addr = 32'h600; d_req_trd = 3'd6;
    tick();
    i_req = 1'b0; d_req = 1'b0;
    tick();
    read_xact("tB_i", 32'h500, 32'h33, 1'b1, 8'h01);
    tick();
    read_xact("tB_d", 32'h600, 32'h44, 1'b0, 8'h40);

    // second request while busy is dropped and flags err
    i_req = 1'b1; i_req_addr = 32'h700; i_req_trd = 3'd2;
    tick();
    chk("ovf_err0", {31'd0, err}, 32'd0);
    i_req_addr = 32'h704;
    tick();
    i_req = 1'b0;
    chk("ovf_err1", {31'd0, err}, 32'd1);
    acc0 = acc_cnt;
    read_xact("ovf", 32'h700, 32'hAB, 1'b1, 8'h04);
    tick();
    tick();
    chk("ovf_acc", acc_cnt - acc0, 32'd1);
    chk("ovf_idle", {31'd0, mem.mem_req}, 32'd0);

    // kill a pending D slot while I waits for data
    i_req = 1'b1; i_req_addr = 32'h800; i_req_trd = 3'd1;
    tick();
    i_req = 1'b0;
    tick();
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    d_req = 1'b1; d_req_addr = 32'h900; d_req_trd = 3'd2;
    tick();
    d_req = 1'b0;
    chk("kp_dbusy", {31'd0, d_busy}, 32'd1);
    kill = 1'b1; kill_trd = 3'd2;
    tick();
    kill = 1'b0;
    chk("kp_dclr", {31'd0, d_busy}, 32'd0);
    acc0 = acc_cnt;
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h77;
    tick();
    mem.mem_rvalid = 1'b0;
    chk("kp_idone", {31'd0, i_done}, 32'd1);
    chk("kp_resume", {24'd0, trd_resume}, 32'h02);
    tick(); tick(); tick();
    chk("kp_noreq", {31'd0, mem.mem_req}, 32'd0);
    chk("kp_acc", acc_cnt - acc0, 32'd0);

    // kill an in-flight D read during ISSUE
    d_req = 1'b1; d_req_addr = 32'hA00; d_req_trd = 3'd3;
    tick();
    d_req = 1'b0;
    tick();
    kill = 1'b1; kill_trd = 3'd3;
    tick();
    kill = 1'b0;
    chk("kf_req_held", {31'd0, mem.mem_req}, 32'd1);
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h99;
    tick();
    mem.mem_rvalid = 1'b0;
    chk("kf_ddone", {31'd0, d_done}, 32'd0);
    chk("kf_resume", {24'd0, trd_resume}, 32'd0);
    tick();
    chk("kf_clr", {31'd0, d_busy}, 32'd0);

    // asynchronous reset mid-access
    i_req = 1'b1; i_req_addr = 32'hB00; i_req_trd = 3'd7;
    tick();
    i_req = 1'b0;
    tick();
    chk("ar_req_pre", {31'd0, mem.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, mem.mem_req}, 32'd0);
    chk("ar_busy", {31'd0, i_busy}, 32'd0);
    chk("ar_err", {31'd0, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("ar_idle", {31'd0, mem.mem_req}, 32'd0);
    chk("ar_fill", fill_data, 32'd0);

`ifdef MEM_TIMEOUT_EN
    i_req = 1'b1; i_req_addr = 32'hC00; i_req_trd = 3'd4;
    tick();
    i_req = 1'b0;
    tick();
    mem.mem_gnt = 1'b1;
    tick();
    mem.mem_gnt = 1'b0;
    repeat (254) tick();
    chk("to_pre_done", {31'd0, i_done}, 32'd0);
    chk("to_pre_err", {31'd0, err}, 32'd0);
    tick();
    chk("to_done", {31'd0, i_done}, 32'd1);
    chk("to_fill", fill_data, 32'hDEAD_BEEF);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_resume", {24'd0, trd_resume}, 32'h10);
    tick();
    mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h1234;
    tick();
    mem.mem_rvalid = 1'b0;
    tick();
    chk("to_late", fill_data, 32'hDEAD_BEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
